mem_share_arbiter: RTL and testbench
====================================

# mem_share_arbiter

Arbiter that shares the single-port data memory between the processor load/store path and the calculator host port. It sits between the pipeline's memory stage and the calculator front end on one side and `MemoriadeDatos` on the other, replacing their direct connection. It grants at most one access per cycle, returns read data one cycle after grant, and enforces fairness.

## Interface

Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `STARVE_MAX`, 8, maximum cycles a pending calculator request waits under fixed priority (range 1..255).

Ports:
- `clk`, in, 1, single clock; all state updates on its rising edge.
- `reset`, in, 1, synchronous, active-high.
- `cpu_req`, in, 1, processor access request.
- `cpu_we`, in, 1, 1 = write, 0 = read.
- `cpu_addr`, in, ADDR_W, processor byte address (ALU result).
- `cpu_wdata`, in, DATA_W, processor store data.
- `cpu_gnt`, out, 1, access accepted this cycle.
- `cpu_rvalid`, out, 1, read data valid.
- `cpu_rdata`, out, DATA_W, read data; 0 when `cpu_rvalid` = 0.
- `calcu_req`, `calcu_we`, `calcu_addr`, `calcu_wdata`, `calcu_gnt`, `calcu_rvalid`, `calcu_rdata`: same widths and meanings as the `cpu_*` ports, for the calculator port.
- `mem_en`, out, 1, memory access strobe.
- `mem_we`, out, 1, memory write enable.
- `mem_addr`, out, ADDR_W, memory address.
- `mem_wdata`, out, DATA_W, memory write data.
- `mem_rdata`, in, DATA_W, synchronous read data, valid the cycle after `mem_en`.

## Operation

- Requester handshake:
  - The requester holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt`.
  - In the cycle after `gnt`, the requester either drops `req` or presents a new transaction.
- Arbitration is combinational from the current inputs and registered state:
  - Exactly one `gnt` is high when any `req` is high.
  - `mem_en` equals the OR of the grants.
  - `mem_we`, `mem_addr` and `mem_wdata` are muxed from the granted port. When no port is granted, they drive 0.
- Policy when both ports request (default build):
  - Round-robin with a 1-bit `last_owner` register.
  - The port that was not granted most recently wins.
  - `last_owner` updates on every grant. Reset value: CALC, so the CPU wins the first conflict.
- Single requester: granted the same cycle, regardless of policy.
- Read response pipeline:
  - A registered `(owner, is_read)` pair captures each granted read.
  - The next cycle, the owner's `rvalid` = 1 and its `rdata` = `mem_rdata`.
  - Writes produce no `rvalid`.
- Back-to-back accesses are allowed. One grant per cycle gives full throughput.
- Reset:
  - While `reset` = 1: all `gnt`, `mem_en` and `mem_we` = 0, so no write occurs.
  - The response pipeline, `last_owner` and the starvation counter are cleared.
  - A read granted the cycle before reset asserts produces no `rvalid`.
- Address and data pass through unmodified. No width arithmetic is performed.

## Timing

- Grant latency: 0 cycles (combinational, same cycle as `req`).
- Read latency: `rvalid` exactly 1 cycle after `gnt`.
- Reset values: `cpu_rvalid` = `calcu_rvalid` = 0; both `rdata` outputs = 0; `last_owner` = CALC; starvation counter = 0.
- Simultaneous requests: the loser's `gnt` stays 0. The loser must hold its request and is granted the next cycle (round-robin).

## Configuration

- `MEM_ARB_FIXED_PRIO_EN` defined:
  - The CPU always wins conflicts.
  - An 8-bit starvation counter increments each cycle that `calcu_req` is high and not granted.
  - When the counter reaches `STARVE_MAX`, the calculator is granted over the CPU.
  - The counter clears on any calculator grant and whenever `calcu_req` = 0.
- Not defined: round-robin as described under Operation. The counter is not built.

## Structure

- Shared package `mem_arb_pkg`:
  - Owner encoding: `OWNER_CPU` = 1'b0, `OWNER_CALC` = 1'b1.
  - Default widths.
- One sub-module, `mem_arb_rsp_pipe`: the registered owner/read-flag pipeline and the `rvalid`/`rdata` demux.
- The top level holds the grant logic, `last_owner` and the starvation counter.

## Test plan

- Reset check:
  - Stimulus: `reset` high with both ports requesting, `we` = 1.
  - Expect: `mem_en` = `mem_we` = 0, no `gnt`, both `rvalid` = 0.
  - After reset: first conflict grants CPU.
- Lone CPU write then read:
  - Stimulus: write `0xDEADBEEF` to `0x10`, then read `0x10`.
  - Expect: `gnt` both cycles; `cpu_rvalid` = 1 and `cpu_rdata` = `0xDEADBEEF` one cycle after the read grant; `calcu_rvalid` stays 0.
- Continuous conflict, default build:
  - Stimulus: both ports read for 6 cycles.
  - Expect: grants alternate CPU, CALC, CPU, …; each `rvalid` is routed to the correct port.
- Interleaved traffic:
  - Stimulus: calculator write `0x5` to `0x20` in the same cycle as a CPU read of `0x20`.
  - Expect: ordering follows the grant order; the CPU sees the old value if granted first.
- Reset mid-read:
  - Stimulus: grant a CPU read, then assert `reset` the next cycle.
  - Expect: `cpu_rvalid` = 0.
- Fixed-priority build, `STARVE_MAX` = 3:
  - Stimulus: CPU requests continuously; calculator requests from cycle 0.
  - Expect: calculator granted in cycle 3; counter returns to 0 afterwards.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory arbiter: owner encoding,
// response-pipeline bundle and default widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    OWNER_CPU  = 1'b0,
    OWNER_CALC = 1'b1
  } owner_e;

  typedef struct packed {
    owner_e owner;
    logic   rd;
  } rsp_t;

endpackage

// File: rtl/mem_arb_rsp_pipe.sv
// Read-response pipeline: remembers who issued the granted read and
// steers the synchronous memory data back to that port next cycle.
module mem_arb_rsp_pipe
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  rsp_t              i_rsp,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_cpu_rvalid,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_calc_rvalid,
  output logic [DATA_W-1:0] o_calc_rdata
);

  rsp_t r_rsp;
  logic w_live;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_rsp <= '0;
    else         r_rsp <= i_rsp;
  end

  // reset also hides a read granted just before it asserted
  assign w_live = r_rsp.rd & ~i_reset;

  assign o_cpu_rvalid  = w_live & (r_rsp.owner == OWNER_CPU);
  assign o_calc_rvalid = w_live & (r_rsp.owner == OWNER_CALC);
  assign o_cpu_rdata   = o_cpu_rvalid  ? i_mem_rdata : '0;
  assign o_calc_rdata  = o_calc_rvalid ? i_mem_rdata : '0;

endmodule

// File: rtl/mem_share_arbiter.sv
// Shares the data memory between CPU and calculator, one grant per cycle.
// MEM_ARB_FIXED_PRIO_EN: CPU priority with calculator starvation guard.
module mem_share_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              calcu_req,
  input  logic              calcu_we,
  input  logic [ADDR_W-1:0] calcu_addr,
  input  logic [DATA_W-1:0] calcu_wdata,
  output logic              calcu_gnt,
  output logic              calcu_rvalid,
  output logic [DATA_W-1:0] calcu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve
    $error("STARVE_MAX out of range 1..255");
  end

  logic w_cpu_wins;
  logic w_cpu_gnt;
  logic w_calc_gnt;
  rsp_t w_rsp;

`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0] r_starve;

  assign w_cpu_wins = (r_starve < STARVE_LIM);

  always_ff @(posedge clk) begin
    if (reset || !calcu_req || w_calc_gnt)
      r_starve <= '0;
    else if (r_starve != 8'hFF)
      r_starve <= r_starve + 8'd1;
  end
`else
  owner_e r_last_owner;

  // the port not served most recently wins a conflict
  assign w_cpu_wins = (r_last_owner == OWNER_CALC);

  always_ff @(posedge clk) begin
    if (reset)           r_last_owner <= OWNER_CALC;
    else if (w_calc_gnt) r_last_owner <= OWNER_CALC;
    else if (w_cpu_gnt)  r_last_owner <= OWNER_CPU;
  end
`endif

  always_comb begin
    w_cpu_gnt  = 1'b0;
    w_calc_gnt = 1'b0;
    if (!reset) begin
      w_cpu_gnt  = cpu_req & (~calcu_req | w_cpu_wins);
      w_calc_gnt = calcu_req & ~w_cpu_gnt;
    end
  end

  assign cpu_gnt   = w_cpu_gnt;
  assign calcu_gnt = w_calc_gnt;
  assign mem_en    = w_cpu_gnt | w_calc_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      w_cpu_gnt: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      w_calc_gnt: begin
        mem_we    = calcu_we;
        mem_addr  = calcu_addr;
        mem_wdata = calcu_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_rsp       = '0;
    w_rsp.owner = w_calc_gnt ? OWNER_CALC : OWNER_CPU;
    w_rsp.rd    = mem_en & ~mem_we;
  end

  mem_arb_rsp_pipe #(
    .DATA_W(DATA_W)
  ) u_rsp (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_rsp        (w_rsp),
    .i_mem_rdata  (mem_rdata),
    .o_cpu_rvalid (cpu_rvalid),
    .o_cpu_rdata  (cpu_rdata),
    .o_calc_rvalid(calcu_rvalid),
    .o_calc_rdata (calcu_rdata)
  );

endmodule

// File: tb/tb_mem_share_arbiter.sv
// Bench for mem_share_arbiter: memory model, directed scenarios,
// random traffic checked every cycle against a reference model.
module tb_mem_share_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 3;

`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam logic [5:0]  EXP_SEQ = 6'b111011;
  localparam logic [31:0] EXP_D   = 32'h0;
`else
  localparam logic [5:0]  EXP_SEQ = 6'b101010;
  localparam logic [31:0] EXP_D   = 32'h5;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          calcu_req = 1'b0, calcu_we = 1'b0;
  logic [AW-1:0] calcu_addr = '0;
  logic [DW-1:0] calcu_wdata = '0;
  logic          calcu_gnt, calcu_rvalid;
  logic [DW-1:0] calcu_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_share_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .calcu_req(calcu_req), .calcu_we(calcu_we),
    .calcu_addr(calcu_addr), .calcu_wdata(calcu_wdata),
    .calcu_gnt(calcu_gnt), .calcu_rvalid(calcu_rvalid),
    .calcu_rdata(calcu_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // synchronous single-port data memory seen by the arbiter
  logic [31:0] ram [0:255];
  initial for (int i = 0; i < 256; i++) ram[i] = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[9:2]];
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // reference model: arbitration rules, response slot, memory contents
  bit          m_last = 1'b1;
  int          m_cnt = 0;
  bit          p_v = 1'b0;
  bit          p_own = 1'b0;
  logic [31:0] p_d = '0;
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  always @(negedge clk) begin : mon
    bit ec, ek, ewe, cpu_first;
    logic [31:0] ea, ed, erc, erk;
    bit evc, evk;
    ec = 0; ek = 0; ewe = 0; ea = '0; ed = '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
    cpu_first = (m_cnt < SM);
`else
    cpu_first = m_last;
`endif
    if (!reset) begin
      if (cpu_req && calcu_req) begin
        ec = cpu_first; ek = !cpu_first;
      end else begin
        ec = cpu_req; ek = calcu_req;
      end
    end
    if (ec) begin ewe = cpu_we; ea = cpu_addr; ed = cpu_wdata; end
    if (ek) begin ewe = calcu_we; ea = calcu_addr; ed = calcu_wdata; end
    evc = p_v && !p_own && !reset;
    evk = p_v && p_own && !reset;
    erc = evc ? p_d : '0;
    erk = evk ? p_d : '0;
    chk("gnt", {30'b0, cpu_gnt, calcu_gnt}, {30'b0, ec, ek});
    chk("mem_ctl", {30'b0, mem_en, mem_we}, {30'b0, ec | ek, ewe});
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ed);
    chk("rvalid", {30'b0, cpu_rvalid, calcu_rvalid}, {30'b0, evc, evk});
    chk("cpu_rdata", cpu_rdata, erc);
    chk("calcu_rdata", calcu_rdata, erk);
    if (reset) begin
      m_last = 1'b1; m_cnt = 0; p_v = 0;
    end else begin
      p_v = 0;
      if (ec || ek) begin
        m_last = ek;
        if (ewe) ref_mem[ea] = ed;
        else begin p_v = 1; p_own = ek; p_d = ref_rd(ea); end
      end
      if (calcu_req && !ek) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      else m_cnt = 0;
    end
  end

  task automatic step(output logic cg, output logic kg);
    @(negedge clk);
    cg = cpu_gnt; kg = calcu_gnt;
    @(posedge clk); #1;
  endtask

  task automatic new_txn(output logic req, output logic we,
                         output logic [31:0] a, output logic [31:0] d);
    req = 1'b1;
    we = 1'($urandom_range(0, 1));
    a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    d = $urandom;
  endtask

  initial begin : drv
    logic cg, kg, got;
    logic [5:0] seq;
    // reset with both ports trying to write
    reset = 1; cpu_req = 1; cpu_we = 1; cpu_addr = 32'h40;
    cpu_wdata = 32'h1111; calcu_req = 1; calcu_we = 1;
    calcu_addr = 32'h44; calcu_wdata = 32'h2222;
    repeat (2) step(cg, kg);
    @(negedge clk);
    chk("rst_quiet", {26'b0, cpu_gnt, calcu_gnt, mem_en, mem_we,
        cpu_rvalid, calcu_rvalid}, 32'h0);
    @(posedge clk); #1;
    // continuous read conflict
    reset = 0; cpu_we = 0; calcu_we = 0;
    cpu_addr = 32'h30; calcu_addr = 32'h34; seq = '0;
    for (int i = 0; i < 6; i++) begin
      step(cg, kg);
      seq = {seq[4:0], cg};
      if (cg) cpu_addr = cpu_addr + 32'h8;
      if (kg) calcu_addr = calcu_addr + 32'h8;
    end
    chk("conflict_seq", {26'b0, seq}, {26'b0, EXP_SEQ});
    cpu_req = 0; calcu_req = 0;
    // lone CPU write then read
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    step(cg, kg);
    chk("wr_gnt", {31'b0, cg}, 32'h1);
    cpu_we = 0;
    step(cg, kg);
    chk("rd_gnt", {31'b0, cg}, 32'h1);
    cpu_req = 0;
    @(negedge clk);
    chk("rd_rvalid", {30'b0, cpu_rvalid, calcu_rvalid}, 32'h2);
    chk("rd_rdata", cpu_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    // calculator write racing a CPU read of the same word
    calcu_req = 1; calcu_we = 1; calcu_addr = 32'h20; calcu_wdata = 32'h5;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
    got = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cpu_rvalid) begin
        got = 1;
        chk("interleave_rdata", cpu_rdata, EXP_D);
      end
      cg = cpu_gnt; kg = calcu_gnt;
      @(posedge clk); #1;
      if (cg) cpu_req = 0;
      if (kg) calcu_req = 0;
    end
    chk("interleave_seen", {31'b0, got}, 32'h1);
    // reset right after a granted read
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    step(cg, kg);
    chk("mid_rd_gnt", {31'b0, cg}, 32'h1);
    cpu_req = 0; reset = 1;
    @(negedge clk);
    chk("mid_rst_rvalid", {31'b0, cpu_rvalid}, 32'h0);
    chk("mid_rst_rdata", cpu_rdata, 32'h0);
    @(posedge clk); #1;
    reset = 0;
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      step(cg, kg);
      if (cg || !cpu_req) begin
        if ($urandom_range(0, 3) != 0)
          new_txn(cpu_req, cpu_we, cpu_addr, cpu_wdata);
        else cpu_req = 0;
      end
      if (kg || !calcu_req) begin
        if ($urandom_range(0, 3) != 0)
          new_txn(calcu_req, calcu_we, calcu_addr, calcu_wdata);
        else calcu_req = 0;
      end
    end
    reset = 0; cpu_req = 0; calcu_req = 0;
    repeat (2) step(cg, kg);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
